// File: rtl/sr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// sr_fetch_pkg
// Shared constants and types for the sr_fetch instruction-fetch stage.
//   INSTR_NOP      : word presented on instr when no instruction is valid
//   PC_STEP        : sequential PC increment
//   FQ_EMPTY/PEND/READY : reservation-queue entry states
//   fetch_pkt_t    : {instr, pc} pair presented at the head of the queue
//   word_align()   : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package sr_fetch_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Entry lifecycle: EMPTY -> PEND (request accepted) -> READY (data back)
    localparam logic [1:0] FQ_EMPTY = 2'd0;
    localparam logic [1:0] FQ_PEND  = 2'd1;
    localparam logic [1:0] FQ_READY = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_pkt_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sr_fetch_if.sv
// ---------------------------------------------------------------------------
// sr_fetch_if
// Bundles the fetch stage's external handshakes:
//   imem_req_valid/ready/addr : request channel to instruction memory
//   imem_rsp_valid/data       : in-order response channel
//   instr_valid/ready/instr/instr_pc : instruction handoff to the core
//   redirect/redirect_pc      : taken-branch redirect from control
// modport master : the fetch stage
// modport slave  : memory + core side
// ---------------------------------------------------------------------------
interface sr_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output redirect, redirect_pc
    );

endinterface

// File: rtl/sr_fetch_queue.sv
// ---------------------------------------------------------------------------
// sr_fetch_queue
// DEPTH-entry reservation queue for the fetch stage. Entries are allocated
// at tail when a request is accepted, filled in request order when the
// response returns, and popped at head when the core consumes them.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   alloc_i/alloc_pc_i : reserve entry[tail] for a request at alloc_pc_i
//   fill_i/fill_data_i : write response into the oldest pending entry
//   pop_i          : consume head (ignored unless head is READY)
//   flush_i        : empty every entry, head=tail=0
//   tail_free_o    : entry[tail] is EMPTY (a request may be issued)
//   any_pend_o     : at least one entry is PENDING
//   pend_cnt_o     : number of PENDING entries
//   head_ready_o   : entry[head] is READY
//   head_o         : {instr, pc} at head (NOP / last shown pc when not READY)
// ---------------------------------------------------------------------------
module sr_fetch_queue
    import sr_fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_i,
    input  logic [31:0]              alloc_pc_i,
    input  logic                     fill_i,
    input  logic [31:0]              fill_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     tail_free_o,
    output logic                     any_pend_o,
    output logic [$clog2(DEPTH):0]   pend_cnt_o,
    output logic                     head_ready_o,
    output fetch_pkt_t               head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]    state_q [DEPTH];
    logic [1:0]    state_d [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   last_pc_q;

    logic          fill_hit;
    logic [PW-1:0] fill_idx;
    logic [CW-1:0] pend_cnt;

    // Responses are in order, so the target of a fill is the first PENDING
    // entry walking forward from head. DEPTH is a power of two, so the index
    // arithmetic wraps naturally.
    always_comb begin
        logic [PW-1:0] idx;
        fill_hit = 1'b0;
        fill_idx = head_q;
        pend_cnt = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (state_q[idx] == FQ_PEND) begin
                pend_cnt = pend_cnt + CW'(1);
                if (!fill_hit) begin
                    fill_hit = 1'b1;
                    fill_idx = idx;
                end
            end
        end
    end

    assign tail_free_o  = (state_q[tail_q] == FQ_EMPTY);
    assign head_ready_o = (state_q[head_q] == FQ_READY);
    assign any_pend_o   = fill_hit;
    assign pend_cnt_o   = pend_cnt;

    always_comb begin
        head_o.instr = head_ready_o ? data_q[head_q] : INSTR_NOP;
        head_o.pc    = head_ready_o ? pc_q[head_q]   : last_pc_q;
    end

    // Alloc, fill and pop always target distinct entries (EMPTY tail,
    // PENDING oldest, READY head), so they are applied independently.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_d[i] = FQ_EMPTY;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            if (alloc_i) begin
                state_d[tail_q] = FQ_PEND;
                tail_d          = tail_q + PW'(1);
            end
            if (fill_i && fill_hit) begin
                state_d[fill_idx] = FQ_READY;
            end
            if (pop_i && head_ready_o) begin
                state_d[head_q] = FQ_EMPTY;
                head_d          = head_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= FQ_EMPTY;
            end
            head_q    <= '0;
            tail_q    <= '0;
            last_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            if (head_ready_o) begin
                last_pc_q <= pc_q[head_q];
            end
        end
    end

    // Payload storage; validity is carried entirely by state_q.
    always_ff @(posedge clk) begin
        if (alloc_i && !flush_i) begin
            pc_q[tail_q] <= alloc_pc_i;
        end
        if (fill_i && fill_hit && !flush_i) begin
            data_q[fill_idx] <= fill_data_i;
        end
    end

endmodule

// File: rtl/sr_fetch.sv
// ---------------------------------------------------------------------------
// sr_fetch
// Instruction fetch stage. Issues sequential word-aligned fetches to
// instruction memory, buffers returned words in sr_fetch_queue and hands
// {instr, instr_pc} to the core. A redirect flushes the queue and arranges
// for responses still in flight to be discarded via drop_cnt.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   bus    : sr_fetch_if.master (memory request/response, core handoff,
//            redirect)
// ---------------------------------------------------------------------------
module sr_fetch
    import sr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    sr_fetch_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Up to DEPTH stale responses per redirect, and a second redirect may
    // land before the first batch drains.
    localparam int DW = $clog2(DEPTH) + 2;

    logic [31:0]   pc_q, pc_d;
    logic [DW-1:0] drop_q, drop_d;

    logic          tail_free;
    logic          any_pend;
    logic [CW-1:0] pend_cnt;
    logic          head_ready;
    fetch_pkt_t    head_pkt;

    logic          req_valid;
    logic          accept;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          fill;
    logic          pop;

    // Request is held off during reset and in a redirect cycle.
    assign req_valid = rst_n & tail_free & ~bus.redirect;
    assign accept    = req_valid & bus.imem_req_ready;
    assign rsp_drop  = bus.imem_rsp_valid & (drop_q != '0);
    assign rsp_keep  = bus.imem_rsp_valid & ~rsp_drop;
    // A live response arriving together with a redirect belongs to the
    // flushed stream, so it is not written.
    assign fill      = rsp_keep & ~bus.redirect;
    assign pop       = head_ready & bus.instr_ready;

    sr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_i      (accept),
        .alloc_pc_i   (pc_q),
        .fill_i       (fill),
        .fill_data_i  (bus.imem_rsp_data),
        .pop_i        (pop),
        .flush_i      (bus.redirect),
        .tail_free_o  (tail_free),
        .any_pend_o   (any_pend),
        .pend_cnt_o   (pend_cnt),
        .head_ready_o (head_ready),
        .head_o       (head_pkt)
    );

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q - DW'(rsp_drop);
        if (bus.redirect) begin
            pc_d = word_align(bus.redirect_pc);
            // Every pending entry will still get a response; the one that
            // arrives this cycle (if any) is already consumed here.
            drop_d = drop_q - DW'(rsp_drop) + DW'(pend_cnt)
                     - DW'(rsp_keep & any_pend);
        end else if (accept) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = head_ready;
    assign bus.instr          = head_pkt.instr;
    assign bus.instr_pc       = head_pkt.pc;

`ifndef SYNTHESIS
    // A response must always have an owner: a stale slot or a pending entry.
    rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.imem_rsp_valid && drop_q == '0) |-> any_pend);
`endif

endmodule

// File: tb/tb_sr_fetch.sv
module tb_sr_fetch;
    import sr_fetch_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sr_fetch_if bus();

    sr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: in-order queue of accepted requests, each tagged with
    // the redirect epoch it was issued in.
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       memq[$];
    int          cyc;
    int          epoch;
    int          occ;       // entries holding a live request or word
    int          rdy;       // words delivered to the queue, not yet consumed
    logic [31:0] exp_req;   // next address the fetch stage must request
    logic [31:0] exp_pop;   // pc of the next instruction the core must see
    bit          post_rst;
    int          n_chk;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs 1 time unit
    // later, then advance the reference model to the state after the edge.
    task automatic cycle(input int rdy_pct, input int irdy_pct, input bit redir,
                         input logic [31:0] tgt, input int lat, input bit do_rst);
        logic acc, pop, good, rv_exp;
        @(negedge clk);
        rst_n              = !do_rst;
        bus.imem_req_ready = do_rst ? 1'b0 : (int'($urandom_range(99)) < rdy_pct);
        bus.instr_ready    = do_rst ? 1'b0 : (int'($urandom_range(99)) < irdy_pct);
        bus.redirect       = redir && !do_rst;
        bus.redirect_pc    = tgt;
        if (!do_rst && memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        if (do_rst) begin
            check("req_valid_in_reset", {31'b0, bus.imem_req_valid}, 32'd0);
            memq.delete();
            occ      = 0;
            rdy      = 0;
            epoch    = epoch + 1;
            exp_req  = RESET_PC;
            exp_pop  = RESET_PC;
            post_rst = 1'b1;
            cyc++;
            return;
        end
        rv_exp = (occ < DEPTH) && !redir;
        check("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, rv_exp});
        if (bus.imem_req_valid) begin
            check("req_addr", bus.imem_req_addr, exp_req);
        end
        check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, rdy > 0});
        if (rdy > 0) begin
            check("instr_pc", bus.instr_pc, exp_pop);
            check("instr", bus.instr, mem_word(exp_pop));
            post_rst = 1'b0;
        end else begin
            check("instr_nop", bus.instr, INSTR_NOP);
            if (post_rst) begin
                check("instr_pc_reset", bus.instr_pc, RESET_PC);
            end
        end
        acc  = bus.imem_req_valid & bus.imem_req_ready;
        pop  = (rdy > 0) & bus.instr_ready;
        good = bus.imem_rsp_valid && (memq[0].epoch == epoch) && !redir;
        if (bus.imem_rsp_valid) begin
            void'(memq.pop_front());
        end
        if (pop) begin
            rdy--;
            occ--;
            exp_pop = exp_pop + 32'd4;
        end
        if (acc) begin
            memq.push_back('{bus.imem_req_addr, cyc + lat, epoch});
            occ++;
            exp_req = exp_req + 32'd4;
        end
        if (good) begin
            rdy++;
        end
        if (redir) begin
            epoch   = epoch + 1;
            occ     = 0;
            rdy     = 0;
            exp_req = {tgt[31:2], 2'b00};
            exp_pop = {tgt[31:2], 2'b00};
        end
        cyc++;
    endtask

    initial begin
        int rp, ip, lat;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        cyc = 0; epoch = 0; occ = 0; rdy = 0;
        exp_req = RESET_PC; exp_pop = RESET_PC; post_rst = 1'b1;
        n_chk = 0; n_fail = 0;

        // Streaming from reset: always-ready memory, 1-cycle latency.
        cycle(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) cycle(100, 100, 0, 0, 1, 0);

        // Core stalled: queue fills with 0 and 4, then requests stop.
        cycle(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) cycle(100, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++)  cycle(100, 100, 0, 0, 1, 0);

        // Redirect to 0x100 with two requests pending, 3-cycle latency.
        cycle(0, 0, 0, 0, 3, 1);
        cycle(100, 0, 0, 0, 3, 0);
        cycle(100, 0, 0, 0, 3, 0);
        cycle(100, 0, 1, 32'h0000_0100, 3, 0);
        for (int i = 0; i < 12; i++) cycle(100, 100, 0, 0, 3, 0);

        // Redirect coinciding with a live response and a pop; unaligned target.
        cycle(0, 0, 0, 0, 1, 1);
        cycle(100, 100, 0, 0, 1, 0);
        cycle(100, 100, 0, 0, 1, 0);
        cycle(100, 100, 1, 32'h0000_0203, 1, 0);
        for (int i = 0; i < 8; i++) cycle(100, 100, 0, 0, 1, 0);

        // PC wrap across the top of the address space.
        cycle(100, 100, 1, 32'hFFFF_FFF8, 1, 0);
        for (int i = 0; i < 10; i++) cycle(100, 100, 0, 0, 1, 0);

        // Reset with two requests outstanding.
        cycle(100, 0, 0, 0, 3, 0);
        cycle(100, 0, 0, 0, 3, 0);
        cycle(0, 0, 0, 0, 3, 1);
        for (int i = 0; i < 8; i++) cycle(100, 100, 0, 0, 2, 0);

        // Randomised traffic with back-to-back redirects allowed.
        for (int seg = 0; seg < 40; seg++) begin
            rp  = int'($urandom_range(20, 100));
            ip  = int'($urandom_range(10, 100));
            lat = int'($urandom_range(1, 4));
            for (int i = 0; i < 60; i++) begin
                cycle(rp, ip, ($urandom_range(99) < 4), $urandom, lat, 0);
            end
            if (seg % 13 == 12) cycle(0, 0, 0, 0, 1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_fetch.md
Name: sr_fetch

Overview:
- Instruction fetch stage directly upstream of the decode/control path.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small reservation queue and presents {instr, instr_pc} to the core with a valid/ready handshake.
- Handles taken-branch redirects (pcSrc from control): flushes the queue and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, queue entries; also the maximum number of outstanding requests (power of 2, at least 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req_valid  out  1  request presented.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- instr_valid  out  1  head of queue holds a returned instruction.
- instr_ready  in  1  core consumes the head this cycle.
- instr  out  32  instruction word at head.
- instr_pc  out  32  PC of that instruction.
- redirect  in  1  taken branch; one-cycle pulse.
- redirect_pc  in  32  branch target; bits [1:0] are forced to 0 internally.

Behaviour:
- Reset (rst_n=0 at edge):
  - pc=RESET_PC; all entries EMPTY; head=tail=0; drop_cnt=0.
  - Outputs: imem_req_valid=0, instr_valid=0, instr=32'h00000013 (NOP), instr_pc=RESET_PC.
  - Reset mid-transaction abandons in-flight responses. The memory model is reset together with the block.
- Entry states: EMPTY -> PENDING (request accepted; pc stored) -> READY (response written) -> EMPTY (popped or flushed).
- Request issue:
  - imem_req_valid = (entry[tail]==EMPTY) & ~redirect.
  - imem_req_addr = pc.
  - On accept (valid & ready): entry[tail]=PENDING with pc; tail++ (mod DEPTH, wraps); pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - A slot freed by a pop is reusable the next cycle, not the same cycle. Queue full means no request is presented.
- Response:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise it is written to the oldest PENDING entry, which becomes READY.
  - imem_rsp_valid with no PENDING entry and drop_cnt=0 is a protocol error: ignored, simulation assertion fires.
- Output:
  - instr_valid = entry[head]==READY; instr/instr_pc come from entry[head], NOP/last pc otherwise.
  - Pop on instr_valid & instr_ready; head++ with wrap.
  - Minimum latency: request accept at cycle N -> response N+1 -> instr_valid at N+2 (response is registered).
- Redirect (cycle N):
  - No request issued in cycle N; a pop in cycle N still completes.
  - At the edge: every entry becomes EMPTY; head=tail=0; pc=redirect_pc & ~3.
  - drop_cnt += number of PENDING entries, minus 1 if a non-dropped response also arrives in cycle N (that response is discarded).
  - First new request in N+1; earliest instr_valid for the target at N+3.
  - A second redirect before the drops drain accumulates into drop_cnt; the maximum is 2*DEPTH, so drop_cnt is $clog2(DEPTH)+2 bits wide.
- Simultaneous request accept, response and pop in one cycle are all legal and independent.
- instr and instr_pc are stable while instr_valid=1 and instr_ready=0.

Decomposition:
- sr_cpu.vh:
  - `INSTR_NOP 32'h00000013
  - entry-state codes `FQ_EMPTY / `FQ_PEND / `FQ_READY
  - `PC_STEP 4
- Sub-module sr_fetch_queue: the DEPTH-entry reservation queue (alloc, fill-oldest, pop, flush, head/tail/state).
- sr_fetch keeps pc, the request handshake and drop_cnt.

Test Plan:
- Reset, memory always ready with 1-cycle latency, instr_ready=1 -> addresses 0,4,8,... issued; instr_pc follows the same sequence; instr_valid first high in cycle 2 after reset release; no gaps are required beyond the queue's credit limit.
- instr_ready=0 for 10 cycles -> exactly DEPTH=2 requests (0,4), then imem_req_valid=0; head holds instr_pc=0 stable; release -> fetch of 8 resumes.
- Memory latency 3 cycles, redirect to 0x100 with 2 requests PENDING -> both stale responses discarded (drop_cnt 2->0); first instr_valid shows instr_pc=0x100 carrying the data for 0x100.
- Redirect in the same cycle as a non-dropped response and a pop -> the pop completes, the response is discarded, drop_cnt = PENDING-1, and the next issued address is the target.
- redirect_pc=0x203 -> imem_req_addr=0x200; pc=0xFFFF_FFFC -> the following request address is 0x0000_0000.
- rst_n=0 for one cycle with 2 requests outstanding -> instr_valid=0, instr=NOP, and the next request after release uses addr=RESET_PC.
